// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU data port, data-memory port and dump byte stream
// that pass through the dump arbiter.
interface dmem_arbiter_if;
  // CPU data port
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        cpu_stall;
  logic        dump_req;
  // data-memory port
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  // dump byte stream towards the host link
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ack;
  logic        dump_busy;
  logic        dump_done;

  // arbiter side
  modport slave (
    input  cpu_we, cpu_addr, cpu_wd, dump_req, mem_rd, byte_ack,
    output cpu_rd, cpu_stall, mem_we, mem_addr, mem_wd,
           byte_out, byte_valid, dump_busy, dump_done
  );

  // environment side (CPU, memory and byte consumer)
  modport master (
    output cpu_we, cpu_addr, cpu_wd, dump_req, mem_rd, byte_ack,
    input  cpu_rd, cpu_stall, mem_we, mem_addr, mem_wd,
           byte_out, byte_valid, dump_busy, dump_done
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the CPU owns the port except for the single
// cycle per word in which the dump engine fetches a word of the dump
// window; fetched words are streamed out LSB byte first.
module dmem_arbiter #(
  parameter logic [31:0] DUMP_BASE  = 32'h0000_0000,
  parameter int          DUMP_WORDS = 16
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] LAST_IDX = 8'(DUMP_WORDS - 1);

  logic [1:0]  state_reg, state_next;
  logic [7:0]  idx_reg, idx_next;
  logic [1:0]  bcnt_reg, bcnt_next;
  logic [31:0] shift_reg, shift_next;
  logic        req_prev_reg;
  logic        byte_valid_reg, byte_valid_next;
  logic        dump_done_reg, dump_done_next;
  logic        req_rise;
  logic        byte_taken;

  assign req_rise   = bus.dump_req && !req_prev_reg;
  assign byte_taken = byte_valid_reg && bus.byte_ack;

  // Next-state logic for the dump sequencer
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    bcnt_next  = bcnt_reg;
    shift_next = shift_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_rise) begin
          state_next = S_FETCH;
          idx_next   = 8'd0;
        end
      end
      S_FETCH: begin
        // memory read is combinational, so the word is available this cycle
        shift_next = bus.mem_rd;
        bcnt_next  = 2'd0;
        state_next = S_SEND;
      end
      S_SEND: begin
        if (byte_taken) begin
          shift_next = {8'h00, shift_reg[31:8]};
          bcnt_next  = bcnt_reg + 2'd1;
          if (bcnt_reg == 2'd3) begin
            if (idx_reg == LAST_IDX) begin
              state_next = S_DONE;
            end else begin
              idx_next   = idx_reg + 8'd1;
              state_next = S_FETCH;
            end
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    byte_valid_next = (state_next == S_SEND);
    dump_done_next  = (state_next == S_DONE);
  end

  // Sequencer registers; reset mid-dump drops the remainder silently
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      idx_reg        <= 8'd0;
      bcnt_reg       <= 2'd0;
      shift_reg      <= 32'd0;
      req_prev_reg   <= 1'b0;
      byte_valid_reg <= 1'b0;
      dump_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      bcnt_reg       <= bcnt_next;
      shift_reg      <= shift_next;
      req_prev_reg   <= bus.dump_req;
      byte_valid_reg <= byte_valid_next;
      dump_done_reg  <= dump_done_next;
    end
  end

  // Port mux: the dump engine takes the port only in FETCH, suppressing
  // any CPU write, which the stalled CPU re-presents the next cycle
  always_comb begin
    bus.mem_we    = bus.cpu_we;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wd    = bus.cpu_wd;
    bus.cpu_stall = 1'b0;
    if (state_reg == S_FETCH) begin
      bus.mem_we    = 1'b0;
      bus.mem_addr  = DUMP_BASE + {22'd0, idx_reg, 2'b00};
      bus.cpu_stall = 1'b1;
    end
  end

  assign bus.cpu_rd     = bus.mem_rd;
  assign bus.byte_out   = shift_reg[7:0];
  assign bus.byte_valid = byte_valid_reg;
  assign bus.dump_done  = dump_done_reg;
  assign bus.dump_busy  = (state_reg != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a two-word dump window at address 0.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .DUMP_BASE  (32'h0000_0000),
    .DUMP_WORDS (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory: combinational read, write on the clock edge
  logic [31:0] mem [0:63];
  assign bus.mem_rd = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wd;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        req;
    logic        ack;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic        e_stall;
    logic        e_bv;
    logic [7:0]  e_byte;
    logic        e_busy;
    logic        e_done;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t       vecs [18];
  logic [7:0] exp_bytes [8];

  function automatic vec_t mk(
    input logic we, input logic [31:0] addr, input logic [31:0] wd,
    input logic req, input logic ack,
    input logic e_mem_we, input logic [31:0] e_mem_addr, input logic e_stall,
    input logic e_bv, input logic [7:0] e_byte, input logic e_busy,
    input logic e_done, input logic chk_rd, input logic [31:0] e_rd);
    vec_t v;
    v.we = we; v.addr = addr; v.wd = wd; v.req = req; v.ack = ack;
    v.e_mem_we = e_mem_we; v.e_mem_addr = e_mem_addr; v.e_stall = e_stall;
    v.e_bv = e_bv; v.e_byte = e_byte; v.e_busy = e_busy; v.e_done = e_done;
    v.chk_rd = chk_rd; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one dump from a dump_req rising edge (caller left dump_req low
  // for the previous cycle). ack is dropped for hold_len cycles while byte
  // hold_byte is presented; dump_req is pulsed low in cycle pulse_at.
  task automatic run_dump(input string tag, input int hold_byte, input int hold_len,
                          input int pulse_at, input int budget);
    int n_bytes = 0;
    int n_stall = 0;
    int n_done  = 0;
    int held    = 0;
    for (int c = 0; c < budget; c++) begin
      bus.dump_req = (c == pulse_at) ? 1'b0 : 1'b1;
      bus.byte_ack = (n_bytes == hold_byte && held < hold_len) ? 1'b0 : 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h0000_0100;
      @(negedge clk);
      if (bus.cpu_stall) n_stall++;
      if (bus.dump_done) n_done++;
      if (!bus.byte_ack) begin
        chk({tag, " hold_valid"}, 32'(bus.byte_valid), 32'd1);
        chk({tag, " hold_byte"}, 32'(bus.byte_out), 32'(exp_bytes[hold_byte]));
        held++;
      end else if (bus.byte_valid) begin
        if (n_bytes < 8)
          chk($sformatf("%s byte%0d", tag, n_bytes), 32'(bus.byte_out), 32'(exp_bytes[n_bytes]));
        else
          chk({tag, " extra_byte"}, 32'(bus.byte_out), 32'hFFFF_FFFF);
        n_bytes++;
      end
      next_cycle();
    end
    chk({tag, " byte_count"}, 32'(n_bytes), 32'd8);
    chk({tag, " stall_cycles"}, 32'(n_stall), 32'd2);
    chk({tag, " done_pulses"}, 32'(n_done), 32'd1);
    $display("dump %s: bytes=%0d stalls=%0d done=%0d", tag, n_bytes, n_stall, n_done);
  endtask

  initial begin
    int n_bytes;
    total = 0;
    bad   = 0;
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    //                  we  addr          wd            req ack  mwe maddr         st bv byte   bsy dn rd  e_rd
    vecs[0]  = mk(1'b1, 32'h00, 32'h4433_2211, 0, 0,   1, 32'h00, 0, 0, 8'h00, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1'b1, 32'h04, 32'h8877_6655, 0, 0,   1, 32'h04, 0, 0, 8'h00, 0, 0, 0, 32'h0);
    vecs[2]  = mk(1'b1, 32'h40, 32'hDEAD_BEEF, 0, 0,   1, 32'h40, 0, 0, 8'h00, 0, 0, 0, 32'h0);
    vecs[3]  = mk(1'b0, 32'h40, 32'h0,         0, 0,   0, 32'h40, 0, 0, 8'h00, 0, 0, 1, 32'hDEAD_BEEF);
    // rising dump_req sampled at the end of this cycle
    vecs[4]  = mk(1'b0, 32'h00, 32'h0,         1, 1,   0, 32'h00, 0, 0, 8'h00, 0, 0, 1, 32'h4433_2211);
    // FETCH word 0; the CPU write to 0x80 is held off
    vecs[5]  = mk(1'b1, 32'h80, 32'h1234_5678, 1, 1,   0, 32'h00, 1, 0, 8'h00, 1, 0, 1, 32'h4433_2211);
    // CPU re-presents the write, which now lands
    vecs[6]  = mk(1'b1, 32'h80, 32'h1234_5678, 1, 1,   1, 32'h80, 0, 1, 8'h11, 1, 0, 0, 32'h0);
    vecs[7]  = mk(1'b0, 32'h80, 32'h0,         1, 1,   0, 32'h80, 0, 1, 8'h22, 1, 0, 1, 32'h1234_5678);
    vecs[8]  = mk(1'b0, 32'h80, 32'h0,         1, 1,   0, 32'h80, 0, 1, 8'h33, 1, 0, 0, 32'h0);
    vecs[9]  = mk(1'b0, 32'h80, 32'h0,         1, 1,   0, 32'h80, 0, 1, 8'h44, 1, 0, 0, 32'h0);
    vecs[10] = mk(1'b0, 32'h80, 32'h0,         1, 1,   0, 32'h04, 1, 0, 8'h00, 1, 0, 1, 32'h8877_6655);
    vecs[11] = mk(1'b0, 32'h80, 32'h0,         1, 1,   0, 32'h80, 0, 1, 8'h55, 1, 0, 0, 32'h0);
    vecs[12] = mk(1'b0, 32'h80, 32'h0,         1, 1,   0, 32'h80, 0, 1, 8'h66, 1, 0, 0, 32'h0);
    vecs[13] = mk(1'b0, 32'h80, 32'h0,         1, 1,   0, 32'h80, 0, 1, 8'h77, 1, 0, 0, 32'h0);
    vecs[14] = mk(1'b0, 32'h80, 32'h0,         1, 1,   0, 32'h80, 0, 1, 8'h88, 1, 0, 0, 32'h0);
    // DONE: 11 cycles counted inclusively from the first FETCH (vec 5)
    vecs[15] = mk(1'b0, 32'h80, 32'h0,         1, 1,   0, 32'h80, 0, 0, 8'h00, 1, 1, 0, 32'h0);
    // dump_req still high: no second dump
    vecs[16] = mk(1'b0, 32'h80, 32'h0,         1, 1,   0, 32'h80, 0, 0, 8'h00, 0, 0, 0, 32'h0);
    vecs[17] = mk(1'b0, 32'h80, 32'h0,         1, 1,   0, 32'h80, 0, 0, 8'h00, 0, 0, 1, 32'h1234_5678);

    // reset; CPU port must pass straight through while held in reset
    reset = 1'b1;
    bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wd = 32'h0;
    bus.dump_req = 1'b0; bus.byte_ack = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst byte_valid", 32'(bus.byte_valid), 32'd0);
    chk("rst byte_out", 32'(bus.byte_out), 32'd0);
    chk("rst dump_busy", 32'(bus.dump_busy), 32'd0);
    chk("rst dump_done", 32'(bus.dump_done), 32'd0);
    chk("rst cpu_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd1);
    chk("rst mem_addr", bus.mem_addr, 32'h10);
    next_cycle();
    reset = 1'b0;
    bus.cpu_we = 1'b0;

    // table-driven pass-through, full dump and write collision
    for (int i = 0; i < 18; i++) begin
      bus.cpu_we   = vecs[i].we;
      bus.cpu_addr = vecs[i].addr;
      bus.cpu_wd   = vecs[i].wd;
      bus.dump_req = vecs[i].req;
      bus.byte_ack = vecs[i].ack;
      @(negedge clk);
      chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_mem_we));
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].e_mem_addr);
      chk($sformatf("v%0d mem_wd", i), bus.mem_wd, vecs[i].wd);
      chk($sformatf("v%0d cpu_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d byte_valid", i), 32'(bus.byte_valid), 32'(vecs[i].e_bv));
      if (vecs[i].e_bv)
        chk($sformatf("v%0d byte_out", i), 32'(bus.byte_out), 32'(vecs[i].e_byte));
      chk($sformatf("v%0d dump_busy", i), 32'(bus.dump_busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d dump_done", i), 32'(bus.dump_done), 32'(vecs[i].e_done));
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d cpu_rd", i), bus.cpu_rd, vecs[i].e_rd);
      $display("vec %0d: we=%0b addr=%h req=%0b -> mem_we=%0b stall=%0b bv=%0b byte=%h busy=%0b done=%0b",
               i, vecs[i].we, vecs[i].addr, vecs[i].req, bus.mem_we, bus.cpu_stall,
               bus.byte_valid, bus.byte_out, bus.dump_busy, bus.dump_done);
      next_cycle();
    end

    // backpressure on the second byte
    bus.dump_req = 1'b0;
    next_cycle();
    run_dump("bp", 1, 5, -1, 22);

    // trigger rules: level held for 30 cycles, then a pulse while busy
    bus.dump_req = 1'b0;
    next_cycle();
    run_dump("hold30", -1, 0, -1, 30);
    bus.dump_req = 1'b0;
    next_cycle();
    run_dump("pulse_busy", -1, 0, 4, 20);

    // reset after three bytes have been accepted
    bus.dump_req = 1'b0;
    bus.byte_ack = 1'b1;
    next_cycle();
    bus.dump_req = 1'b1;
    n_bytes = 0;
    for (int c = 0; c < 12 && n_bytes < 3; c++) begin
      @(negedge clk);
      if (bus.byte_valid) n_bytes++;
      next_cycle();
    end
    chk("rstmid bytes_before", 32'(n_bytes), 32'd3);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.dump_req = 1'b0;
    @(negedge clk);
    chk("rstmid byte_valid", 32'(bus.byte_valid), 32'd0);
    chk("rstmid dump_busy", 32'(bus.dump_busy), 32'd0);
    chk("rstmid dump_done", 32'(bus.dump_done), 32'd0);
    $display("reset mid-dump after %0d bytes: bv=%0b busy=%0b done=%0b",
             n_bytes, bus.byte_valid, bus.dump_busy, bus.dump_done);
    next_cycle();
    run_dump("restart", -1, 0, -1, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the pipelined CPU and a result-dump engine that streams a fixed window of data memory out, byte by byte, to the host interpreter link. It sits between the CPU data port and data memory. While no dump is running the CPU owns the port transparently. A dump is triggered by the CPU's COM flag; the CPU is stalled only on the cycles the dump engine reads memory.

## Interface
- DUMP_BASE, 32'h0000_0000, byte address of first dumped word (word aligned)
- DUMP_WORDS, 16, number of 32-bit words dumped per request (1..256)

- clk  in  1  system clock (CPU clock)
- reset  in  1  synchronous, active-high
- cpu_we  in  1  CPU write enable
- cpu_addr  in  32  CPU byte address
- cpu_wd  in  32  CPU write data
- cpu_rd  out  32  read data returned to CPU (= mem_rd)
- cpu_stall  out  1  CPU must hold its memory stage this cycle
- dump_req  in  1  COM flag from CPU; rising edge starts a dump
- mem_we  out  1  data-memory write enable
- mem_addr  out  32  data-memory address
- mem_wd  out  32  data-memory write data
- mem_rd  in  32  data-memory read data (combinational read)
- byte_out  out  8  current dump byte
- byte_valid  out  1  byte_out valid
- byte_ack  in  1  consumer accepts byte_out this cycle
- dump_busy  out  1  dump in progress
- dump_done  out  1  one-cycle pulse after the final byte is accepted

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - mem_* = cpu_* pass-through; cpu_stall=0; byte_valid=0.
  - A dump_req rising edge (registered previous value 0, current 1) moves to FETCH, with word index idx=0.
- FETCH (exactly 1 cycle):
  - mem_addr = DUMP_BASE + 4*idx; mem_we=0; cpu_stall=1.
  - Any CPU write in this cycle is suppressed; the CPU re-presents it because it is stalled.
  - The registered 32-bit shift register loads mem_rd; byte counter bcnt=0.
  - Next state is SEND.
- SEND:
  - Port returns to the CPU (pass-through, cpu_stall=0).
  - byte_valid=1, byte_out = shift[7:0] (little-endian, LSB byte first).
  - On byte_valid&&byte_ack: shift right by 8 and bcnt++.
  - If that was the 4th byte (bcnt==3) and idx==DUMP_WORDS-1: go to DONE.
  - If it was the 4th byte otherwise: idx++ and go to FETCH.
  - Otherwise stay in SEND; byte_valid stays high with the next byte.
- DONE (1 cycle): dump_done=1, byte_valid=0, pass-through; next state is IDLE.
- dump_busy=1 in FETCH, SEND and DONE.
- dump_req edges while dump_busy are ignored (not queued).
- idx width is 8 bits. Address arithmetic is 32-bit modulo 2^32; wrap-around past 32'hFFFF_FFFC is permitted and not flagged.
- cpu_rd always equals mem_rd. In FETCH the CPU ignores it because cpu_stall is high.

## Timing
- Reset values:
  - state=IDLE, idx=0, bcnt=0, shift=0, registered dump_req=0.
  - byte_out=0, byte_valid=0, dump_busy=0, dump_done=0, cpu_stall=0.
  - mem_* follow cpu_* (pass-through).
- Reset asserted mid-dump aborts it on the next edge. No dump_done is produced and the remaining bytes are dropped.
- Latency:
  - dump_req edge sampled at edge N gives FETCH in cycle N+1 and the first byte_valid in cycle N+2.
  - With byte_ack held high, a full dump takes DUMP_WORDS*5 + 1 cycles from FETCH entry to dump_done.
- byte_out and byte_valid are registered. byte_out is stable while byte_valid=1 and byte_ack=0.
- byte_ack while byte_valid=0 is ignored.
- cpu_stall is combinational from state (high iff FETCH).
- The CPU may write the dump window during SEND. Words not yet fetched reflect the new data; the word already in the shift register does not.
- dump_req held high for many cycles triggers only one dump. A new dump needs a low-then-high transition after dump_busy falls, or a rising edge in the IDLE cycle following DONE.

## Test plan
- CPU pass-through in IDLE:
  - Write 32'hDEAD_BEEF to 0x40, then read 0x40.
  - Required: mem_we mirrors cpu_we, cpu_rd=32'hDEAD_BEEF, cpu_stall never asserted, byte_valid=0.
- Full dump with DUMP_WORDS=2, DUMP_BASE=0:
  - Memory word 0 = 32'h4433_2211, word 1 = 32'h8877_6655; byte_ack tied high.
  - Required bytes in order: 11,22,33,44,55,66,77,88.
  - cpu_stall high for exactly 2 cycles; dump_done pulses once, 11 cycles after the first FETCH.
- Backpressure:
  - byte_ack low for 5 cycles during the 2nd byte.
  - Required: byte_out holds 8'h22 with byte_valid=1 for all 5 cycles and no byte is lost or duplicated.
- Write collision:
  - cpu_we=1 to 0x80 with data 32'h1234_5678 during a FETCH cycle.
  - Required: mem_we=0 that cycle. The write lands on the following cycle (CPU still presenting it) and memory at 0x80 = 32'h1234_5678.
- Trigger rules:
  - dump_req held high for 30 cycles, then a second pulse while dump_busy.
  - Required: exactly one dump and one dump_done.
- Reset mid-SEND after 3 bytes:
  - Required: next cycle byte_valid=0, dump_busy=0, dump_done=0. A subsequent dump_req edge restarts from idx 0 with byte 8'h11.
